maq_bcd: RTL and testbench

Parametrised two-digit BCD modulo counter stage for the digital clock, the general replacement for the fixed seconds/minutes/hours counters. It counts between MIN_VALUE and MAX_VALUE in either direction and accepts a synchronous preset for time setting. A registered one-cycle carry/borrow pulse and a same-cycle terminal-count flag let stages be cascaded, e.g. seconds to minutes to hours.

---
 rtl/maq_bcd.sv | 153 +++++++++++++++
 tb/tb_maq_bcd.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/maq_bcd.sv
// maq_bcd: two-digit BCD modulo counter stage for the digital clock.
//
// Counts between MIN_VALUE and MAX_VALUE, upward or downward, and accepts a
// synchronous preset for time setting. Stages cascade by wiring one stage's
// combinational terminal count into the next stage's incremento, so that a
// whole chain wraps on a single edge.
//
// Parameters:
//   MAX_VALUE  highest count, decimal (1..99, fits in MSD_WIDTH tens digit)
//   MIN_VALUE  lowest count, decimal (0..MAX_VALUE-1)
//   MSD_WIDTH  width of the tens digit (1..4)
//
// Ports:
//   maqbcd_clock       rising-edge clock
//   maqbcd_reset       synchronous active-high reset, loads MIN_VALUE
//   maqbcd_enable      gates stepping only; load works regardless
//   maqbcd_incremento  step request, sampled each edge
//   maqbcd_down        0 = count up, 1 = count down
//   maqbcd_load        synchronous preset strobe (beats a step)
//   maqbcd_load_lsd    preset units digit
//   maqbcd_load_msd    preset tens digit
//   maqbcd_Lsd         registered units digit
//   maqbcd_Msd         registered tens digit
//   maqbcd_carry       one-cycle pulse with the MAX->MIN wrapped value
//   maqbcd_borrow      one-cycle pulse with the MIN->MAX wrapped value
//   maqbcd_tc          combinational terminal count (this step will wrap)
//   maqbcd_load_err    one-cycle pulse after a rejected preset
module maq_bcd #(
  parameter int MAX_VALUE = 59,
  parameter int MIN_VALUE = 0,
  parameter int MSD_WIDTH = 3
) (
  input  logic                 maqbcd_clock,
  input  logic                 maqbcd_reset,
  input  logic                 maqbcd_enable,
  input  logic                 maqbcd_incremento,
  input  logic                 maqbcd_down,
  input  logic                 maqbcd_load,
  input  logic [3:0]           maqbcd_load_lsd,
  input  logic [MSD_WIDTH-1:0] maqbcd_load_msd,
  output logic [3:0]           maqbcd_Lsd,
  output logic [MSD_WIDTH-1:0] maqbcd_Msd,
  output logic                 maqbcd_carry,
  output logic                 maqbcd_borrow,
  output logic                 maqbcd_tc,
  output logic                 maqbcd_load_err
);

  // Value width: wide enough for 10*15+9 so that even a corrupted tens digit
  // can never alias back into the legal range.
  localparam int VW = 8;

  localparam logic [3:0]           MIN_LSD = 4'(MIN_VALUE % 10);
  localparam logic [MSD_WIDTH-1:0] MIN_MSD = MSD_WIDTH'(MIN_VALUE / 10);
  localparam logic [3:0]           MAX_LSD = 4'(MAX_VALUE % 10);
  localparam logic [MSD_WIDTH-1:0] MAX_MSD = MSD_WIDTH'(MAX_VALUE / 10);

  function automatic int bcd_value(input logic [MSD_WIDTH-1:0] msd,
                                   input logic [3:0]           lsd);
    logic [VW-1:0] v;
    v = VW'(msd) * VW'(10) + VW'(lsd);
    return int'(v);
  endfunction

  function automatic logic bcd_legal(input logic [MSD_WIDTH-1:0] msd,
                                     input logic [3:0]           lsd);
    int v;
    v = bcd_value(msd, lsd);
    return (lsd <= 4'd9) && (v >= MIN_VALUE) && (v <= MAX_VALUE);
  endfunction

  logic [3:0]           lsd_q, lsd_d;
  logic [MSD_WIDTH-1:0] msd_q, msd_d;
  logic                 carry_d, borrow_d, load_err_d;
  logic                 step_req;
  logic                 at_max, at_min, cur_legal;

  assign step_req  = !maqbcd_load && maqbcd_enable && maqbcd_incremento;
  assign at_max    = (bcd_value(msd_q, lsd_q) == MAX_VALUE) && (lsd_q <= 4'd9);
  assign at_min    = (bcd_value(msd_q, lsd_q) == MIN_VALUE) && (lsd_q <= 4'd9);
  assign cur_legal = bcd_legal(msd_q, lsd_q);

  assign maqbcd_tc = step_req && (maqbcd_down ? at_min : at_max);

  // NOTE: every signal written here gets a default first, so no path through
  // the branches can leave one unassigned and infer a latch.
  always_comb begin
    lsd_d      = lsd_q;
    msd_d      = msd_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;

    if (maqbcd_load) begin
      if (bcd_legal(maqbcd_load_msd, maqbcd_load_lsd)) begin
        lsd_d = maqbcd_load_lsd;
        msd_d = maqbcd_load_msd;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (step_req) begin
      if (!cur_legal) begin
        // Corrupted state: recover to MIN silently.
        lsd_d = MIN_LSD;
        msd_d = MIN_MSD;
      end else if (!maqbcd_down) begin
        if (at_max) begin
          lsd_d   = MIN_LSD;
          msd_d   = MIN_MSD;
          carry_d = 1'b1;
        end else if (lsd_q == 4'd9) begin
          lsd_d = 4'd0;
          msd_d = msd_q + MSD_WIDTH'(1);
        end else begin
          lsd_d = lsd_q + 4'd1;
        end
      end else begin
        if (at_min) begin
          lsd_d    = MAX_LSD;
          msd_d    = MAX_MSD;
          borrow_d = 1'b1;
        end else if (lsd_q == 4'd0) begin
          lsd_d = 4'd9;
          msd_d = msd_q - MSD_WIDTH'(1);
        end else begin
          lsd_d = lsd_q - 4'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge maqbcd_clock) begin
    if (maqbcd_reset) begin
      lsd_q           <= MIN_LSD;
      msd_q           <= MIN_MSD;
      maqbcd_carry    <= 1'b0;
      maqbcd_borrow   <= 1'b0;
      maqbcd_load_err <= 1'b0;
    end else begin
      lsd_q           <= lsd_d;
      msd_q           <= msd_d;
      maqbcd_carry    <= carry_d;
      maqbcd_borrow   <= borrow_d;
      maqbcd_load_err <= load_err_d;
    end
  end

  assign maqbcd_Lsd = lsd_q;
  assign maqbcd_Msd = msd_q;

endmodule

// File: tb/tb_maq_bcd.sv
// Directed bench for maq_bcd: a default 00..59 stage and a 01..12 hours
// stage share one clock; each is exercised while the other sits idle.
module tb_maq_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stage A: default parameters (59/0, MSD_WIDTH 3)
  logic       a_reset, a_enable, a_inc, a_down, a_load;
  logic [3:0] a_load_lsd, a_lsd;
  logic [2:0] a_load_msd, a_msd;
  logic       a_carry, a_borrow, a_tc, a_load_err;

  // Stage B: hours (12/1, MSD_WIDTH 1)
  logic       b_reset, b_enable, b_inc, b_down, b_load;
  logic [3:0] b_load_lsd, b_lsd;
  logic [0:0] b_load_msd, b_msd;
  logic       b_carry, b_borrow, b_tc, b_load_err;

  maq_bcd u_sec (
    .maqbcd_clock(clk), .maqbcd_reset(a_reset), .maqbcd_enable(a_enable),
    .maqbcd_incremento(a_inc), .maqbcd_down(a_down), .maqbcd_load(a_load),
    .maqbcd_load_lsd(a_load_lsd), .maqbcd_load_msd(a_load_msd),
    .maqbcd_Lsd(a_lsd), .maqbcd_Msd(a_msd), .maqbcd_carry(a_carry),
    .maqbcd_borrow(a_borrow), .maqbcd_tc(a_tc), .maqbcd_load_err(a_load_err)
  );

  maq_bcd #(.MAX_VALUE(12), .MIN_VALUE(1), .MSD_WIDTH(1)) u_hrs (
    .maqbcd_clock(clk), .maqbcd_reset(b_reset), .maqbcd_enable(b_enable),
    .maqbcd_incremento(b_inc), .maqbcd_down(b_down), .maqbcd_load(b_load),
    .maqbcd_load_lsd(b_load_lsd), .maqbcd_load_msd(b_load_msd),
    .maqbcd_Lsd(b_lsd), .maqbcd_Msd(b_msd), .maqbcd_carry(b_carry),
    .maqbcd_borrow(b_borrow), .maqbcd_tc(b_tc), .maqbcd_load_err(b_load_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int a_val();
    return int'(a_msd) * 10 + int'(a_lsd);
  endfunction

  function automatic int b_val();
    return int'(b_msd) * 10 + int'(b_lsd);
  endfunction

  task automatic a_load_val(input int v);
    a_load     = 1'b1;
    a_load_msd = 3'(v / 10);
    a_load_lsd = 4'(v % 10);
    tick();
    a_load     = 1'b0;
  endtask

  int exp_v;

  initial begin
    a_reset = 1'b1; a_enable = 1'b0; a_inc = 1'b0; a_down = 1'b0;
    a_load = 1'b0; a_load_lsd = '0; a_load_msd = '0;
    b_reset = 1'b1; b_enable = 1'b0; b_inc = 1'b0; b_down = 1'b0;
    b_load = 1'b0; b_load_lsd = '0; b_load_msd = '0;
    #2;

    // ---------------- Stage A: reset state ----------------
    tick();
    check("a_reset_val", a_val(), 0);
    check("a_reset_carry", a_carry, 0);
    check("a_reset_borrow", a_borrow, 0);
    check("a_reset_err", a_load_err, 0);
    a_reset = 1'b0;

    // 60 steps up: full cycle back to 00, carry only on the wrap.
    a_enable = 1'b1; a_inc = 1'b1; a_down = 1'b0;
    exp_v = 0;
    for (int i = 1; i <= 60; i++) begin
      #1;
      check($sformatf("a_up_tc_%0d", i), a_tc, (exp_v == 59) ? 1 : 0);
      tick();
      exp_v = (exp_v == 59) ? 0 : exp_v + 1;
      check($sformatf("a_up_val_%0d", i), a_val(), exp_v);
      check($sformatf("a_up_carry_%0d", i), a_carry, (i == 60) ? 1 : 0);
    end
    check("a_up_final", a_val(), 0);

    // Step down from reset: 00 -> 59 with borrow, then 58 without.
    a_inc = 1'b0;
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    a_inc = 1'b1; a_down = 1'b1;
    #1; check("a_dn_tc_at_min", a_tc, 1);
    tick();
    check("a_dn_wrap_val", a_val(), 59);
    check("a_dn_wrap_borrow", a_borrow, 1);
    check("a_dn_wrap_carry", a_carry, 0);
    check("a_dn_tc_at_59", a_tc, 0);
    tick();
    check("a_dn_next_val", a_val(), 58);
    check("a_dn_next_borrow", a_borrow, 0);
    a_inc = 1'b0; a_down = 1'b0;

    // Loads
    a_load_val(42);
    check("a_load42_val", a_val(), 42);
    check("a_load42_err", a_load_err, 0);
    a_load_val(60);
    check("a_load60_val", a_val(), 42);
    check("a_load60_err", a_load_err, 1);
    tick();
    check("a_err_pulse_clr", a_load_err, 0);
    a_load = 1'b1; a_load_msd = 3'd0; a_load_lsd = 4'd11;
    tick();
    a_load = 1'b0;
    check("a_load_lsd11_val", a_val(), 42);
    check("a_load_lsd11_err", a_load_err, 1);

    // Load beats a step; tc is masked by load even at MAX.
    a_load_val(59);
    a_inc = 1'b1; a_load = 1'b1; a_load_msd = 3'd1; a_load_lsd = 4'd1;
    #1; check("a_tc_masked_by_load", a_tc, 0);
    tick();
    check("a_load_step_val", a_val(), 11);
    check("a_load_step_carry", a_carry, 0);
    check("a_load_step_err", a_load_err, 0);
    a_load = 1'b0; a_inc = 1'b0;

    // enable = 0: incremento pulsing has no effect; load still works.
    a_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_inc = (i % 2 == 0);
      #1;
      check($sformatf("a_dis_tc_%0d", i), a_tc, 0);
      tick();
      check($sformatf("a_dis_val_%0d", i), a_val(), 11);
      check($sformatf("a_dis_pulse_%0d", i), a_carry | a_borrow, 0);
    end
    a_inc = 1'b0;
    a_load_val(33);
    check("a_dis_load_val", a_val(), 33);

    // Reset on the same edge as a 59->00 wrap: no carry survives.
    a_enable = 1'b1;
    a_load_val(59);
    a_inc = 1'b1; a_reset = 1'b1;
    tick();
    check("a_rst_wrap_val", a_val(), 0);
    check("a_rst_wrap_carry", a_carry, 0);
    a_reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("a_post_rst_val_%0d", i), a_val(), i);
    end
    a_inc = 1'b0; a_enable = 1'b0;

    // ---------------- Stage B: hours 01..12 ----------------
    tick();
    check("b_reset_val", b_val(), 1);
    b_reset = 1'b0;
    b_enable = 1'b1; b_inc = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      tick();
      check($sformatf("b_up_val_%0d", i), b_val(), i);
    end
    #1; check("b_tc_at_12", b_tc, 1);
    tick();
    check("b_wrap_val", b_val(), 1);
    check("b_wrap_carry", b_carry, 1);
    b_down = 1'b1;
    tick();
    check("b_dn_wrap_val", b_val(), 12);
    check("b_dn_wrap_borrow", b_borrow, 1);
    check("b_dn_wrap_carry", b_carry, 0);
    b_inc = 1'b0; b_down = 1'b0;
    // Preset below MIN (00) is rejected.
    b_load = 1'b1; b_load_msd = 1'b0; b_load_lsd = 4'd0;
    tick();
    b_load = 1'b0;
    check("b_load00_val", b_val(), 12);
    check("b_load00_err", b_load_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
